// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if
// Fetch-side and write-back-side signal bundle for the program-counter
// generator.
//   master : the PC generator itself (drives addr/addr_valid/flush/misalign*)
//   slave  : the environment (fetch unit + ALU-WB stage)
// Signals
//   stall          freeze fetch issue
//   addr           current fetch address
//   addr_valid     addr is a live fetch request
//   fetch_ready    fetch accepts addr this cycle
//   fetch_is_ctl   accepted instruction is control-flow
//   fetch_len4     accepted instruction is 4 bytes (2-byte alignment only)
//   wb_valid       ALU-WB result valid
//   wb_jmp_op      0 none, 1 jump, 2 conditional branch, 3 reserved
//   wb_cmp         branch condition
//   wb_target      jump/branch target
//   wb_fault       WB fault
//   flush          redirect accepted this cycle (combinational)
//   misalign       one-cycle pulse, redirect target was misaligned
//   misalign_addr  last offending target
// ---------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] addr;
    logic            addr_valid;
    logic            fetch_ready;
    logic            fetch_is_ctl;
    logic            fetch_len4;
    logic            wb_valid;
    logic [1:0]      wb_jmp_op;
    logic            wb_cmp;
    logic [XLEN-1:0] wb_target;
    logic            wb_fault;
    logic            flush;
    logic            misalign;
    logic [XLEN-1:0] misalign_addr;

    modport master (
        input  stall, fetch_ready, fetch_is_ctl, fetch_len4,
        input  wb_valid, wb_jmp_op, wb_cmp, wb_target, wb_fault,
        output addr, addr_valid, flush, misalign, misalign_addr
    );

    modport slave (
        output stall, fetch_ready, fetch_is_ctl, fetch_len4,
        output wb_valid, wb_jmp_op, wb_cmp, wb_target, wb_fault,
        input  addr, addr_valid, flush, misalign, misalign_addr
    );
endinterface

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Program-counter generator for the fetch front end. Issues sequential fetch
// addresses, parks in WAIT after a control-flow instruction is accepted, and
// takes redirects / faults from the ALU-WB stage. Misaligned redirect targets
// are replaced by TRAP_VECTOR and reported on misalign/misalign_addr.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : pc_gen_if.master (fetch handshake, WB redirect, flush, misalign)
// Parameters
//   XLEN, RESET_VECTOR, TRAP_VECTOR, IALIGN (2 or 4)
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = '0,
    parameter int              IALIGN       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_gen_if.master   bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [XLEN-1:0] addr_q,  addr_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [0:0]      state_q, state_d;
    logic            mis_q,   mis_d;

    logic            handshake;
    logic            wb_fault_take;
    logic            wb_taken;
    logic            wb_not_taken;
    logic [XLEN-1:0] step;

    function automatic logic misaligned(input logic [XLEN-1:0] t);
        return t[0] | ((IALIGN == 4) & t[1]);
    endfunction

    // Reset gates addr_valid combinationally so fetch sees no request while rst_n is low.
    assign bus.addr_valid = rst_n & (state_q == ST_RUN) & ~bus.stall;
    assign handshake      = bus.addr_valid & bus.fetch_ready;

    assign wb_fault_take = bus.wb_valid & bus.wb_fault;
    assign wb_taken      = bus.wb_valid & ((bus.wb_jmp_op == 2'd1) |
                                           ((bus.wb_jmp_op == 2'd2) & bus.wb_cmp));
    assign wb_not_taken  = bus.wb_valid & (bus.wb_jmp_op == 2'd2) & ~bus.wb_cmp;

    assign step = ((IALIGN == 4) || bus.fetch_len4) ? XLEN'(4) : XLEN'(2);

    // A same-cycle handshake is dropped whenever a redirect or fault wins; flush tells fetch.
    assign bus.flush = wb_fault_take | wb_taken;

    always_comb begin
        addr_d  = addr_q;
        state_d = state_q;
        mis_d   = 1'b0;
        maddr_d = maddr_q;
        if (wb_fault_take) begin
            addr_d  = TRAP_VECTOR;
            state_d = ST_RUN;
        end else if (wb_taken) begin
            state_d = ST_RUN;
            if (misaligned(bus.wb_target)) begin
                addr_d  = TRAP_VECTOR;
                mis_d   = 1'b1;
                maddr_d = bus.wb_target;
            end else begin
                addr_d  = bus.wb_target;
            end
        end else if (wb_not_taken) begin
            // Fall-through address was already issued before entering WAIT.
            state_d = ST_RUN;
        end else if (handshake) begin
            addr_d = addr_q + step;
            if (bus.fetch_is_ctl) begin
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= RESET_VECTOR;
            state_q <= ST_RUN;
            mis_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            addr_q  <= addr_d;
            state_q <= state_d;
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
        end
    end

    assign bus.addr          = addr_q;
    assign bus.misalign      = mis_q;
    assign bus.misalign_addr = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        ready = 1'b0;
    logic        is_ctl = 1'b0;
    logic        len4 = 1'b0;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_op = 2'd0;
    logic        wb_cmp = 1'b0;
    logic [31:0] wb_target = 32'd0;
    logic        wb_fault = 1'b0;

    pc_gen_if #(.XLEN(32)) if4 ();
    pc_gen_if #(.XLEN(32)) if2 ();

    assign if4.stall = stall;      assign if2.stall = stall;
    assign if4.fetch_ready = ready; assign if2.fetch_ready = ready;
    assign if4.fetch_is_ctl = is_ctl; assign if2.fetch_is_ctl = is_ctl;
    assign if4.fetch_len4 = len4;  assign if2.fetch_len4 = len4;
    assign if4.wb_valid = wb_valid; assign if2.wb_valid = wb_valid;
    assign if4.wb_jmp_op = wb_op;  assign if2.wb_jmp_op = wb_op;
    assign if4.wb_cmp = wb_cmp;    assign if2.wb_cmp = wb_cmp;
    assign if4.wb_target = wb_target; assign if2.wb_target = wb_target;
    assign if4.wb_fault = wb_fault; assign if2.wb_fault = wb_fault;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .TRAP_VECTOR(32'h80), .IALIGN(4))
        u_pc4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h40), .IALIGN(2))
        u_pc2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // DUT outputs gathered per instance (0: IALIGN=4, 1: IALIGN=2)
    logic [31:0] d_addr [2];
    logic        d_valid[2];
    logic        d_flush[2];
    logic        d_mis  [2];
    logic [31:0] d_maddr[2];
    assign d_addr[0] = if4.addr;          assign d_addr[1] = if2.addr;
    assign d_valid[0] = if4.addr_valid;   assign d_valid[1] = if2.addr_valid;
    assign d_flush[0] = if4.flush;        assign d_flush[1] = if2.flush;
    assign d_mis[0] = if4.misalign;       assign d_mis[1] = if2.misalign;
    assign d_maddr[0] = if4.misalign_addr; assign d_maddr[1] = if2.misalign_addr;

    // Reference model
    int unsigned P_IA[2] = '{4, 2};
    logic [31:0] P_RV[2] = '{32'h100, 32'h0};
    logic [31:0] P_TV[2] = '{32'h80, 32'h40};

    logic [31:0] m_addr [2];
    bit          m_wait [2];
    bit          m_mis  [2];
    logic [31:0] m_maddr[2];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = P_RV[k]; m_wait[k] = 0; m_mis[k] = 0; m_maddr[k] = 32'd0;
        end
    endtask

    function automatic bit is_mis(input logic [31:0] t, input int unsigned ia);
        return (t % 2 != 0) || (ia == 4 && t % 4 != 0);
    endfunction

    // Compute next model state from current inputs, wait for the edge, then commit.
    task automatic tick();
        logic [31:0] na[2];
        bit nw[2];
        bit nm[2];
        logic [31:0] nma[2];
        bit taken;
        bit live;
        for (int k = 0; k < 2; k++) begin
            na[k] = m_addr[k]; nw[k] = m_wait[k]; nm[k] = 0; nma[k] = m_maddr[k];
            taken = wb_valid && (wb_op == 1 || (wb_op == 2 && wb_cmp));
            live  = !m_wait[k] && !stall;
            if (!rst_n) begin
                na[k] = P_RV[k]; nw[k] = 0; nma[k] = 0;
            end else if (wb_valid && wb_fault) begin
                na[k] = P_TV[k]; nw[k] = 0;
            end else if (taken) begin
                nw[k] = 0;
                if (is_mis(wb_target, P_IA[k])) begin
                    na[k] = P_TV[k]; nm[k] = 1; nma[k] = wb_target;
                end else begin
                    na[k] = wb_target;
                end
            end else if (wb_valid && wb_op == 2) begin
                nw[k] = 0;
            end else if (live && ready) begin
                na[k] = m_addr[k] + ((P_IA[k] == 4 || len4) ? 32'd4 : 32'd2);
                nw[k] = is_ctl;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = na[k]; m_wait[k] = nw[k]; m_mis[k] = nm[k]; m_maddr[k] = nma[k];
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc_addr%0d", k), d_addr[k], m_addr[k]);
                chk($sformatf("cyc_valid%0d", k), 32'(d_valid[k]),
                    32'(rst_n && !m_wait[k] && !stall));
                chk($sformatf("cyc_flush%0d", k), 32'(d_flush[k]),
                    32'(wb_valid && (wb_fault || wb_op == 1 || (wb_op == 2 && wb_cmp))));
                chk($sformatf("cyc_mis%0d", k), 32'(d_mis[k]), 32'(m_mis[k]));
                chk($sformatf("cyc_maddr%0d", k), d_maddr[k], m_maddr[k]);
            end
        end
    end

    task automatic idle();
        stall = 0; ready = 0; is_ctl = 0; len4 = 0;
        wb_valid = 0; wb_op = 0; wb_cmp = 0; wb_target = 0; wb_fault = 0;
    endtask

    initial begin
        idle();
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_addr4", if4.addr, 32'h100);
        chk("rst_addr2", if2.addr, 32'h0);
        chk("rst_valid4", 32'(if4.addr_valid), 32'd0);
        chk("rst_mis4", 32'(if4.misalign), 32'd0);
        chk("rst_maddr4", if4.misalign_addr, 32'd0);
        chk_en = 1'b1;
        tick(); tick();

        // Sequential fetch: 4-byte steps on IALIGN=4, mixed on IALIGN=2
        rst_n = 1'b1; ready = 1;
        #1 chk("valid_after_rst", 32'(if4.addr_valid), 32'd1);
        len4 = 0; tick();
        chk("seq4_0", if4.addr, 32'h104); chk("seq2_0", if2.addr, 32'h2);
        len4 = 1; tick();
        chk("seq4_1", if4.addr, 32'h108); chk("seq2_1", if2.addr, 32'h6);
        len4 = 0; tick();
        chk("seq4_2", if4.addr, 32'h10C); chk("seq2_2", if2.addr, 32'h8);

        // Jump to 0x20 with a colliding handshake, then control-flow fetch into WAIT
        wb_valid = 1; wb_op = 1; wb_target = 32'h20;
        #1 chk("jmp_flush", 32'(if4.flush), 32'd1);
        tick();
        chk("jmp_addr4", if4.addr, 32'h20); chk("jmp_addr2", if2.addr, 32'h20);
        wb_valid = 0; wb_op = 0; is_ctl = 1; len4 = 1; tick();
        chk("wait_addr", if4.addr, 32'h24);
        chk("wait_valid", 32'(if4.addr_valid), 32'd0);
        is_ctl = 0; wb_valid = 1; wb_op = 2; wb_cmp = 0;
        #1 chk("nt_flush", 32'(if4.flush), 32'd0);
        tick();
        wb_valid = 0; wb_op = 0;
        #1 chk("nt_addr", if4.addr, 32'h24);
        chk("nt_valid", 32'(if4.addr_valid), 32'd1);

        // Misaligned jump from WAIT
        is_ctl = 1; tick();
        is_ctl = 0; ready = 0; wb_valid = 1; wb_op = 1; wb_target = 32'h2002;
        #1 chk("mis_flush", 32'(if4.flush), 32'd1);
        tick();
        chk("mis_addr4", if4.addr, 32'h80);
        chk("mis_pulse", 32'(if4.misalign), 32'd1);
        chk("mis_maddr", if4.misalign_addr, 32'h2002);
        chk("mis_addr2", if2.addr, 32'h2002);
        chk("mis_none2", 32'(if2.misalign), 32'd0);
        wb_valid = 0; wb_op = 0; tick();
        chk("mis_end", 32'(if4.misalign), 32'd0);
        chk("mis_hold", if4.misalign_addr, 32'h2002);

        // Fault colliding with a handshake
        ready = 1; wb_valid = 1; wb_fault = 1;
        #1 chk("flt_flush", 32'(if2.flush), 32'd1);
        tick();
        chk("flt_addr4", if4.addr, 32'h80); chk("flt_addr2", if2.addr, 32'h40);
        wb_valid = 0; wb_fault = 0;

        // Stall holds everything
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_addr", if4.addr, 32'h80);
            chk("stall_valid", 32'(if4.addr_valid), 32'd0);
        end
        stall = 0;

        // Wrap-around
        ready = 0; wb_valid = 1; wb_op = 1; wb_target = 32'hFFFF_FFFC; tick();
        wb_valid = 0; wb_op = 0; ready = 1; len4 = 1;
        #1 chk("wrap_pre", if4.addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap4", if4.addr, 32'h0); chk("wrap2", if2.addr, 32'h0);

        // Asynchronous reset while in WAIT
        is_ctl = 1; tick();
        is_ctl = 0; ready = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_addr4", if4.addr, 32'h100);
        chk("arst_addr2", if2.addr, 32'h0);
        chk("arst_valid", 32'(if4.addr_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("arst_run", 32'(if4.addr_valid), 32'd1);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            stall  = ($urandom_range(0, 7) == 0);
            ready  = ($urandom_range(0, 3) != 0);
            is_ctl = ($urandom_range(0, 3) == 0);
            len4   = $urandom_range(0, 1);
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_op    = 2'($urandom_range(0, 3));
            wb_cmp   = $urandom_range(0, 1);
            wb_fault = ($urandom_range(0, 15) == 0);
            wb_target = $urandom;
            if ($urandom_range(0, 2) != 0) wb_target[1:0] = 2'b00;
            if ($urandom_range(0, 31) == 0) wb_target = 32'hFFFF_FFFC;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        idle();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
